// File: rtl/mac_pkg.sv
// Shared operand-path constants and lane types for the mac_pe array and its feeders.
package mac_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int OUTPUT_WIDTH = 2 * DATA_WIDTH + 8;

    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef struct packed {
        data_t data;
        logic  valid;
        logic  last;
    } lane_t;

endpackage

// File: rtl/mac_skew_line.sv
// Fixed-length shift register used as one lane's skew delay.
// Latency: DELAY cycles from din to dout.
// Backpressure: none; shifts every cycle, synchronous clear empties every stage.
module mac_skew_line #(
    parameter int DELAY = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DELAY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DELAY; k++) stage[k] <= '0;
        end else begin
            stage[0] <= din;
            for (int k = 1; k < DELAY; k++) stage[k] <= stage[k-1];
        end
    end

    assign dout = stage[DELAY-1];

endmodule

// File: rtl/mac_skew_feeder.sv
// Buffers operand vectors and emits them diagonally skewed to the array edge (lane i delayed i cycles).
// Latency: lane i valid i+2 edges after a push into an empty idle feeder (FIFO stage + i+1 skew regs).
// Backpressure: s_ready drops only when the FIFO is full; the skew chain always drains, run only gates pops.
module mac_skew_feeder
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = mac_pkg::DATA_WIDTH,
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             run,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [LANES*DATA_WIDTH-1:0]      s_data,
    input  logic                             s_last,
    output logic [LANES*DATA_WIDTH-1:0]      a_out,
    output logic [LANES-1:0]                 valid_out,
    output logic                             tile_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  level,
    output logic                             busy
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int VW = LANES * DATA_WIDTH;

    logic [VW:0]    mem [FIFO_DEPTH];   // {last tag, vector}
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [LW-1:0]  count;
    logic           push;
    logic           pop;
    logic [VW:0]    head;

    assign s_ready = (count != LW'(FIFO_DEPTH));
    assign push    = s_valid && s_ready;
    assign pop     = run && (count != '0);
    assign head    = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {s_last, s_data};
    end

    // Only the final lane carries the last tag; it alone drives tile_done.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int W = (i == LANES - 1) ? DATA_WIDTH + 2 : DATA_WIDTH + 1;
        logic [W-1:0] din;
        logic [W-1:0] dout;

        if (i == LANES - 1) begin : g_tag
            assign din       = pop ? {head[VW], 1'b1, head[i*DATA_WIDTH +: DATA_WIDTH]} : '0;
            assign tile_done = dout[DATA_WIDTH+1] & dout[DATA_WIDTH];
        end else begin : g_notag
            assign din = pop ? {1'b1, head[i*DATA_WIDTH +: DATA_WIDTH]} : '0;
        end

        mac_skew_line #(
            .DELAY (i + 1),
            .WIDTH (W)
        ) u_line (
            .clk  (clk),
            .rst  (rst),
            .din  (din),
            .dout (dout)
        );

        assign valid_out[i]                       = dout[DATA_WIDTH];
        assign a_out[i*DATA_WIDTH +: DATA_WIDTH]  = dout[DATA_WIDTH] ? dout[DATA_WIDTH-1:0] : '0;
    end

    // Every lane is fed the same pop stream and lane j's output shows what sits in
    // stage j of the deepest lane, so "any stage valid" equals "any lane output valid".
    assign busy = (count != '0) || (|valid_out);

endmodule

// File: tb/tb_mac_skew_feeder.sv
// Bench for mac_skew_feeder: cycle-exact vector table plus per-lane scoreboard of pushed vectors.
module tb_mac_skew_feeder;

    localparam int DW = 8;
    localparam int NL = 4;
    localparam int FD = 4;

    logic          clk;
    logic          rst;
    logic          run;
    logic          s_valid;
    logic          s_ready;
    logic [31:0]   s_data;
    logic          s_last;
    logic [31:0]   a_out;
    logic [3:0]    valid_out;
    logic          tile_done;
    logic [2:0]    level;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    logic mon_en = 1'b0;

    logic [8:0] sbq [NL][$];

    mac_skew_feeder #(
        .DATA_WIDTH (DW),
        .LANES      (NL),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .a_out     (a_out),
        .valid_out (valid_out),
        .tile_done (tile_done),
        .level     (level),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard producer: record every accepted vector per lane.
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NL; k++) sbq[k].delete();
        end else if (s_valid && s_ready) begin
            for (int k = 0; k < NL; k++) sbq[k].push_back({s_last, s_data[k*DW +: DW]});
        end
    end

    // Scoreboard consumer: each valid lane element must be the next expected one.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < NL; k++) begin
                if (valid_out[k]) begin
                    if (sbq[k].size() == 0) begin
                        chk("sb_unexpected_lane_valid", 64'(k), 64'hFF);
                    end else begin
                        logic [8:0] e;
                        e = sbq[k].pop_front();
                        chk("sb_lane_data", 64'(a_out[k*DW +: DW]), 64'(e[7:0]));
                        if (k == NL - 1) chk("sb_tile_done", 64'(tile_done), 64'(e[8]));
                    end
                end else begin
                    chk("sb_idle_lane_zero", 64'(a_out[k*DW +: DW]), 64'h0);
                    if (k == NL - 1) chk("sb_tile_done_idle", 64'(tile_done), 64'h0);
                end
            end
        end
    end

    typedef struct {
        logic        run;
        logic        vld;
        logic        last;
        logic [31:0] dat;
        logic [3:0]  exp_v;
        logic [31:0] exp_a;
        logic        exp_td;
        logic [2:0]  exp_lvl;
        logic        exp_busy;
    } row_t;

    row_t tbl [14];

    function automatic row_t mk(input logic r, input logic v, input logic l, input logic [31:0] d,
                                input logic [3:0] ev, input logic [31:0] ea, input logic etd,
                                input logic [2:0] el, input logic eb);
        row_t x;
        x.run = r; x.vld = v; x.last = l; x.dat = d;
        x.exp_v = ev; x.exp_a = ea; x.exp_td = etd; x.exp_lvl = el; x.exp_busy = eb;
        return x;
    endfunction

    function automatic logic [31:0] vec(input logic [7:0] base);
        logic [7:0] b0, b1, b2, b3;
        b0 = base; b1 = base + 8'd1; b2 = base + 8'd2; b3 = base + 8'd3;
        return {b3, b2, b1, b0};
    endfunction

    task automatic run_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            run = tbl[r].run; s_valid = tbl[r].vld; s_last = tbl[r].last; s_data = tbl[r].dat;
            step();
            chk($sformatf("row%0d_valid_out", r), 64'(valid_out), 64'(tbl[r].exp_v));
            chk($sformatf("row%0d_a_out", r), 64'(a_out), 64'(tbl[r].exp_a));
            chk($sformatf("row%0d_tile_done", r), 64'(tile_done), 64'(tbl[r].exp_td));
            chk($sformatf("row%0d_level", r), 64'(level), 64'(tbl[r].exp_lvl));
            chk($sformatf("row%0d_s_ready", r), 64'(s_ready), 64'h1);
            chk($sformatf("row%0d_busy", r), 64'(busy), 64'(tbl[r].exp_busy));
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic drain();
        s_valid = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 40 && busy; i++) step();
        chk("drain_busy_timeout", 64'(busy), 64'h0);
    endtask

    initial begin
        // single-vector tile
        tbl[0]  = mk(1, 1, 1, 32'h04030201, 4'b0000, 32'h00000000, 0, 3'd1, 1);
        tbl[1]  = mk(1, 0, 0, 32'h0,        4'b0001, 32'h00000001, 0, 3'd0, 1);
        tbl[2]  = mk(1, 0, 0, 32'h0,        4'b0010, 32'h00000200, 0, 3'd0, 1);
        tbl[3]  = mk(1, 0, 0, 32'h0,        4'b0100, 32'h00030000, 0, 3'd0, 1);
        tbl[4]  = mk(1, 0, 0, 32'h0,        4'b1000, 32'h04000000, 1, 3'd0, 1);
        tbl[5]  = mk(1, 0, 0, 32'h0,        4'b0000, 32'h00000000, 0, 3'd0, 0);
        // three back-to-back vectors, last on V2
        tbl[6]  = mk(1, 1, 0, 32'h0D0C0B0A, 4'b0000, 32'h00000000, 0, 3'd1, 1);
        tbl[7]  = mk(1, 1, 0, 32'h17161514, 4'b0001, 32'h0000000A, 0, 3'd1, 1);
        tbl[8]  = mk(1, 1, 1, 32'h21201F1E, 4'b0011, 32'h00000B14, 0, 3'd1, 1);
        tbl[9]  = mk(1, 0, 0, 32'h0,        4'b0111, 32'h000C151E, 0, 3'd0, 1);
        tbl[10] = mk(1, 0, 0, 32'h0,        4'b1110, 32'h0D161F00, 0, 3'd0, 1);
        tbl[11] = mk(1, 0, 0, 32'h0,        4'b1100, 32'h17200000, 0, 3'd0, 1);
        tbl[12] = mk(1, 0, 0, 32'h0,        4'b1000, 32'h21000000, 1, 3'd0, 1);
        tbl[13] = mk(1, 0, 0, 32'h0,        4'b0000, 32'h00000000, 0, 3'd0, 0);

        // reset held two cycles with s_valid asserted
        rst = 1'b1; run = 1'b0; s_valid = 1'b1; s_last = 1'b1; s_data = 32'hDEADBEEF;
        step();
        mon_en = 1'b1;
        step();
        chk("rst_a_out", 64'(a_out), 64'h0);
        chk("rst_valid_out", 64'(valid_out), 64'h0);
        chk("rst_tile_done", 64'(tile_done), 64'h0);
        chk("rst_level", 64'(level), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_s_ready", 64'(s_ready), 64'h1);
        rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        step();

        run_rows(0, 5);
        run_rows(6, 13);

        // FIFO fills with run low, fifth vector held until a pop frees space
        run = 1'b0; s_valid = 1'b1; s_last = 1'b0;
        for (int v = 0; v < 4; v++) begin
            s_data = vec(8'(8'h40 + 4 * v));
            step();
        end
        chk("full_level", 64'(level), 64'd4);
        chk("full_s_ready", 64'(s_ready), 64'h0);
        s_data = vec(8'h50); s_last = 1'b1;
        step();
        step();
        chk("held_level", 64'(level), 64'd4);
        chk("held_valid_out", 64'(valid_out), 64'h0);
        run = 1'b1;
        step();
        chk("resume_level", 64'(level), 64'd3);
        chk("resume_s_ready", 64'(s_ready), 64'h1);
        chk("resume_lane0", 64'(a_out[7:0]), 64'h40);
        step();
        chk("fifth_accepted_level", 64'(level), 64'd3);
        s_last = 1'b0;
        drain();

        // full FIFO with sustained push and pop
        run = 1'b0; s_valid = 1'b1;
        for (int v = 0; v < 4; v++) begin
            s_data = vec(8'(8'h80 + 4 * v));
            step();
        end
        chk("stream_full_level", 64'(level), 64'd4);
        run = 1'b1;
        begin
            int n;
            logic acc;
            n = 4;
            for (int c = 0; c < 10; c++) begin
                s_data = vec(8'(8'h80 + 4 * n));
                acc = s_valid && s_ready;
                step();
                if (acc) n++;
                chk($sformatf("stream_level_c%0d", c), 64'(level), 64'd3);
            end
            chk("stream_accepted", 64'(n), 64'd13);
        end
        drain();

        // reset mid-tile discards the tile without a tile_done
        run = 1'b1; s_valid = 1'b1; s_last = 1'b1; s_data = vec(8'h60);
        step();
        s_valid = 1'b0; s_last = 1'b0;
        step();
        step();
        chk("midtile_lane1_valid", 64'(valid_out), 64'b0010);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid_out", 64'(valid_out), 64'h0);
        chk("midrst_a_out", 64'(a_out), 64'h0);
        chk("midrst_level", 64'(level), 64'h0);
        chk("midrst_busy", 64'(busy), 64'h0);
        chk("midrst_tile_done", 64'(tile_done), 64'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("midrst_no_tile_done", 64'(tile_done), 64'h0);
        end
        run_rows(0, 5);

        for (int k = 0; k < NL; k++) chk($sformatf("sb_lane%0d_empty", k), 64'(sbq[k].size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
